// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into short press, double click, long press and
// auto-repeat strobes, timing everything in 1 kHz ticks so the clk frequency does not matter.
module button_event_decoder #(
   parameter int   LONG_MS     = 800,
   parameter int   DOUBLE_MS   = 300,
   parameter int   REPEAT_MS   = 200,
   parameter logic PRESS_LEVEL = 1'b1,
   parameter int   CNT_W       = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ButtonIn,
   input  logic       pulse1kHz,
   output logic       ShortPress,
   output logic       DoubleClick,
   output logic       LongPress,
   output logic       Repeat,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS1   = 3'd1,
      WAIT2    = 3'd2,
      HOLD     = 3'd3,
      WAIT_REL = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_MS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_q, btn_d;
   logic             short_q, short_d;
   logic             double_q, double_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;

   logic pressed;
   logic press_edge;
   logic release_edge;
   logic tick;

   always_comb begin
      pressed      = (ButtonIn == PRESS_LEVEL);
      btn_d        = pressed;
      press_edge   = pressed & ~btn_q;
      release_edge = ~pressed & btn_q;
      tick         = pulse1kHz;

      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;

      // Edges always win over a tick arriving in the same cycle; the limit compare
      // happens before the increment, so cnt never reaches the limit itself.
      case (state_q)
         IDLE: begin
            if (press_edge) begin
               state_d = PRESS1;
               cnt_d   = '0;
            end
         end
         PRESS1: begin
            if (release_edge) begin
               state_d = WAIT2;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == LONG_LAST) begin
                  long_d  = 1'b1;
                  state_d = HOLD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         HOLD: begin
            if (release_edge) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == REPEAT_LAST) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         WAIT2: begin
            if (press_edge) begin
               double_d = 1'b1;
               state_d  = WAIT_REL;
               cnt_d    = '0;
            end else if (tick) begin
               if (cnt_q == DOUBLE_LAST) begin
                  short_d = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         WAIT_REL: begin
            if (release_edge) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // btn_q resets to released so a button held through reset is seen as a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         btn_q    <= 1'b0;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         btn_q    <= btn_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
      end
   end

   assign ShortPress  = short_q;
   assign DoubleClick = double_q;
   assign LongPress   = long_q;
   assign Repeat      = repeat_q;
   assign State       = state_q;

endmodule
